// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one word-granular memory port between the icache and
// the dcache. Round-robin arbitration; a grant is held for a whole
// transaction (a BURST-word line fill or a single write-through word).
//
// Ports:
//   i_clk, i_rst_n              clock, asynchronous active-low reset
//   i_ic_mem_* / o_ic_mem_*     icache memory-side interface
//   i_dc_mem_* / o_dc_mem_*     dcache memory-side interface
//   o_mem_* / i_mem_*           external memory port
//   o_owner                     00 none, 01 icache, 10 dcache
//   o_arb_busy                  a transaction is in progress
module mem_arbiter #(
    parameter int BURST = 4,
    parameter int CW    = 3
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [31:0] i_ic_mem_addr,
    input  logic        i_ic_mem_ren,
    input  logic        i_ic_mem_wen,
    input  logic [31:0] i_ic_mem_wdata,
    output logic        o_ic_mem_ready,
    output logic [31:0] o_ic_mem_rdata,
    output logic        o_ic_mem_valid,
    input  logic [31:0] i_dc_mem_addr,
    input  logic        i_dc_mem_ren,
    input  logic        i_dc_mem_wen,
    input  logic [31:0] i_dc_mem_wdata,
    output logic        o_dc_mem_ready,
    output logic [31:0] o_dc_mem_rdata,
    output logic        o_dc_mem_valid,
    output logic [31:0] o_mem_addr,
    output logic        o_mem_ren,
    output logic        o_mem_wen,
    output logic [31:0] o_mem_wdata,
    input  logic        i_mem_ready,
    input  logic [31:0] i_mem_rdata,
    input  logic        i_mem_valid,
    output logic [1:0]  o_owner,
    output logic        o_arb_busy
);

    typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

    localparam logic [1:0]    OWN_NONE = 2'b00;
    localparam logic [1:0]    OWN_IC   = 2'b01;
    localparam logic [1:0]    OWN_DC   = 2'b10;
    localparam logic [CW-1:0] BURST_C  = CW'(BURST);
    localparam logic [CW-1:0] LAST_C   = CW'(BURST - 1);

    state_t        state, state_nxt;
    logic [1:0]    owner, owner_nxt;
    logic [1:0]    last_owner, last_nxt;
    logic [CW-1:0] icnt, icnt_nxt;
    logic [CW-1:0] rcnt, rcnt_nxt;

    // Owner-side request mux; only meaningful outside IDLE.
    logic        sel_dc;
    logic [31:0] sel_addr, sel_wdata;
    logic        sel_ren, sel_wen;

    assign sel_dc    = (owner == OWN_DC);
    assign sel_addr  = sel_dc ? i_dc_mem_addr  : i_ic_mem_addr;
    assign sel_wdata = sel_dc ? i_dc_mem_wdata : i_ic_mem_wdata;
    assign sel_ren   = sel_dc ? i_dc_mem_ren   : i_ic_mem_ren;
    assign sel_wen   = sel_dc ? i_dc_mem_wen   : i_ic_mem_wen;

    logic ic_req, dc_req;
    assign ic_req = i_ic_mem_ren | i_ic_mem_wen;
    assign dc_req = i_dc_mem_ren | i_dc_mem_wen;

    logic [1:0] win;
    logic       win_wen;
    logic       room;
    logic       own_ready, own_valid;

    always_comb begin
        state_nxt   = state;
        owner_nxt   = owner;
        last_nxt    = last_owner;
        icnt_nxt    = icnt;
        rcnt_nxt    = rcnt;
        win         = OWN_NONE;
        win_wen     = 1'b0;
        room        = 1'b0;
        own_ready   = 1'b0;
        own_valid   = 1'b0;
        o_mem_addr  = 32'h0;
        o_mem_ren   = 1'b0;
        o_mem_wen   = 1'b0;
        o_mem_wdata = 32'h0;

        case (state)
            IDLE: begin
                if (ic_req || dc_req) begin
                    // On a tie the master that did not own the port last wins.
                    if (ic_req && dc_req)
                        win = (last_owner == OWN_IC) ? OWN_DC : OWN_IC;
                    else
                        win = ic_req ? OWN_IC : OWN_DC;
                    // wen outranks ren if a master raises both.
                    win_wen   = (win == OWN_DC) ? i_dc_mem_wen : i_ic_mem_wen;
                    state_nxt = win_wen ? WRITE : READ;
                    owner_nxt = win;
                    last_nxt  = win;
                    icnt_nxt  = '0;
                    rcnt_nxt  = '0;
                end
            end
            READ: begin
                // Once BURST reads are issued the owner's ren is no longer forwarded.
                room        = (icnt < BURST_C);
                o_mem_addr  = sel_addr;
                o_mem_wdata = sel_wdata;
                o_mem_ren   = sel_ren && room;
                own_ready   = i_mem_ready && room;
                if (own_ready && sel_ren)
                    icnt_nxt = icnt + CW'(1);
                if (i_mem_valid) begin
                    own_valid = 1'b1;
                    rcnt_nxt  = rcnt + CW'(1);
                    if (rcnt == LAST_C) begin
                        state_nxt = IDLE;
                        owner_nxt = OWN_NONE;
                    end
                end
            end
            WRITE: begin
                o_mem_addr  = sel_addr;
                o_mem_wdata = sel_wdata;
                o_mem_wen   = sel_wen;
                own_ready   = i_mem_ready;
                if (own_ready && sel_wen) begin
                    state_nxt = IDLE;
                    owner_nxt = OWN_NONE;
                end
            end
            default: begin
                state_nxt = IDLE;
                owner_nxt = OWN_NONE;
            end
        endcase

        o_ic_mem_ready = own_ready && (owner == OWN_IC);
        o_dc_mem_ready = own_ready && (owner == OWN_DC);
        o_ic_mem_valid = own_valid && (owner == OWN_IC);
        o_dc_mem_valid = own_valid && (owner == OWN_DC);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= IDLE;
            owner      <= OWN_NONE;
            last_owner <= OWN_DC;   // icache wins the first tie
            icnt       <= '0;
            rcnt       <= '0;
        end else begin
            state      <= state_nxt;
            owner      <= owner_nxt;
            last_owner <= last_nxt;
            icnt       <= icnt_nxt;
            rcnt       <= rcnt_nxt;
        end
    end

    assign o_ic_mem_rdata = i_mem_rdata;
    assign o_dc_mem_rdata = i_mem_rdata;
    assign o_owner        = owner;
    assign o_arb_busy     = (state != IDLE);

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single external word-granular memory port between the instruction cache and the data cache.
- Each cache connects through its own memory-side interface: addr, ren, wen, wdata, ready, rdata, valid.
- Arbitration is round-robin. A grant is locked for a whole transaction: a BURST-word line fill, or a single write-through word.
- The block sits between the two cache instances and the memory model. Neither cache needs modification.

Parameters:
- BURST, 4, words per line fill (read beats per read grant); minimum 1.
- CW, 3, width of beat counters; must hold BURST.

Ports:
- i_clk  input  1  global clock
- i_rst_n  input  1  asynchronous active-low reset
- i_ic_mem_addr  input  32  icache request address
- i_ic_mem_ren  input  1  icache read request
- i_ic_mem_wen  input  1  icache write request (normally 0)
- i_ic_mem_wdata  input  32  icache write data
- o_ic_mem_ready  output  1  icache may issue/accept this cycle
- o_ic_mem_rdata  output  32  read data (broadcast)
- o_ic_mem_valid  output  1  read data valid for icache
- i_dc_mem_addr, i_dc_mem_ren, i_dc_mem_wen, i_dc_mem_wdata, o_dc_mem_ready, o_dc_mem_rdata, o_dc_mem_valid: same as ic, for dcache
- o_mem_addr  output  32  memory address
- o_mem_ren  output  1  memory read
- o_mem_wen  output  1  memory write
- o_mem_wdata  output  32  memory write data
- i_mem_ready  input  1  memory accepts request
- i_mem_rdata  input  32  memory read data
- i_mem_valid  input  1  memory read data valid
- o_owner  output  2  00 none, 01 icache, 10 dcache
- o_arb_busy  output  1  state != IDLE

Behaviour:
- Acceptance: a request is accepted when ren or wen is high and the corresponding ready is high on the same edge.
- States: IDLE, READ, WRITE. Registers: owner, last_owner, issued count icnt, returned count rcnt.
- IDLE:
  - Both ready=0. All o_mem_* = 0. Both valid=0. i_mem_valid is ignored.
  - A master requests if ren|wen.
  - One requester: it wins.
  - Both request: the master != last_owner wins.
  - Winner with wen -> WRITE; with ren -> READ.
  - On transition: owner=winner, last_owner=winner, icnt=rcnt=0.
  - One-cycle arbitration latency, no combinational bypass.
- READ:
  - o_mem_addr/ren/wdata come from the owner; o_mem_wen=0.
  - Owner ready = i_mem_ready && icnt<BURST. Non-owner ready=0.
  - Each accepted read: icnt+1.
  - Owner valid = i_mem_valid; non-owner valid=0. Each valid: rcnt+1.
  - An accept and a valid on the same edge both count.
  - When rcnt reaches BURST (the edge of the final valid) -> IDLE.
  - Owner ren after icnt==BURST is not forwarded (o_mem_ren=0).
- WRITE:
  - o_mem_addr/wen/wdata come from the owner; o_mem_ren=0.
  - Owner ready = i_mem_ready.
  - First accepted write -> IDLE next edge.
  - i_mem_valid is ignored; both valid=0.
- Back-to-back transactions: at least one IDLE cycle between any two grants, including same-master grants.
- Non-owner requests are held off by ready=0. Requesters keep their request lines stable while waiting.
- o_ic_mem_rdata = o_dc_mem_rdata = i_mem_rdata at all times.
- Reset (async, any state):
  - state=IDLE, owner=00, last_owner=dcache (icache wins the first tie), icnt=rcnt=0.
  - All outputs 0 during and immediately after reset.
  - Memory responses arriving after reset are dropped because the block is in IDLE.
- Illegal input (ren&wen from the same master in IDLE): wen takes precedence, -> WRITE.
- Counters never wrap: icnt saturates at BURST; rcnt is compared before increment.

Test Plan:
- Single icache fill: ic ren addr 0x100, memory ready=1, valid 2 cycles after each accept. Expect: owner=01 the cycle after request; o_mem_addr follows the cache (0x100, 0x104, 0x108, 0x10C); 4 ic valids, dc valid=0; IDLE after the 4th valid.
- Simultaneous request after reset: ic ren + dc wen (0x200, data 0xDEADBEEF) in the same cycle. Expect: icache granted first; dc ready=0 throughout the fill; then dcache WRITE with o_mem_wen=1, addr 0x200, wdata 0xDEADBEEF; last_owner=10.
- Round-robin fairness: both continuously request reads. Expect grants alternating ic, dc, ic, dc, with exactly one IDLE cycle between grants.
- Backpressure: i_mem_ready low for 3 cycles mid-fill. Expect icnt frozen, owner ready=0, no extra o_mem_ren beyond 4 accepts, fill completes correctly.
- Same-edge accept/valid: a valid coincides with the next accept. Expect both counters advance; exactly 4 valids delivered; no 5th o_mem_ren.
- Reset mid-READ after 2 valids: i_rst_n low for 1 cycle, memory returns 2 further valids. Expect IDLE, o_owner=00, valids not forwarded, next tie grants icache.
